pit_down_counter: RTL and testbench

- 16-bit loadable down-counter with a terminal-count flag, modelled on a single 8254 PIT counter element in mode 0 (interrupt on terminal count).
- Software/control logic loads a start value.
- The counter decrements once per clock while counting is permitted.
- counting_complete rises when the count reaches zero and stays high until the next load.
- Used as the core counting element inside the PIT top level.

---
 rtl/pit_down_counter.sv | 49 ++++
 tb/tb_pit_down_counter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pit_down_counter.sv
// Single 8254-style counter element in mode 0: loadable down-counter whose
// terminal-count flag stays high from the edge the count reaches zero until the next load.
module pit_down_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] new_count,
    output logic             counting_complete
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             armed_q, armed_d;
    logic             done_q,  done_d;

    // Load beats counting; enable is an active-low gate and only matters once armed.
    always_comb begin
        count_d = count_q;
        armed_d = armed_q;
        done_d  = done_q;
        if (load) begin
            count_d = new_count;
            armed_d = 1'b1;
            done_d  = 1'b0;
        end else if (!enable && armed_q) begin
            count_d = count_q - WIDTH'(1);
            if (count_q == WIDTH'(1)) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            armed_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            armed_q <= armed_d;
            done_q  <= done_d;
        end
    end

    assign counting_complete = done_q;

endmodule

// File: tb/tb_pit_down_counter.sv
// Self-checking bench for pit_down_counter: directed vector table, hand-written
// long sequences, and randomized traffic checked against an elapsed-count model.
module tb_pit_down_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic        enable = 1'b1;
    logic [15:0] new_count = '0;
    logic        counting_complete;

    int checks = 0;
    int failures = 0;

    // Model: the flag is high once the number of count edges since the last
    // load reaches the loaded value (zero meaning 65536).
    bit m_armed = 1'b0;
    int m_target = 0;
    int m_elapsed = 0;

    typedef struct {
        logic        rst;
        logic        load;
        logic        enable;
        logic [15:0] nc;
        logic        exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    pit_down_counter #(.WIDTH(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .load              (load),
        .enable            (enable),
        .new_count         (new_count),
        .counting_complete (counting_complete)
    );

    always #5 clk = ~clk;

    function automatic logic model_cc();
        return m_armed && (m_elapsed >= m_target);
    endfunction

    task automatic applyStimulus(input logic r, input logic l, input logic e, input logic [15:0] nc);
        rst       = r;
        load      = l;
        enable    = e;
        new_count = nc;
        @(posedge clk);
        #1;
        if (r) begin
            m_armed   = 1'b0;
            m_target  = 0;
            m_elapsed = 0;
        end else if (l) begin
            m_armed   = 1'b1;
            m_target  = (nc == 16'd0) ? 65536 : int'(nc);
            m_elapsed = 0;
        end else if (!e && m_armed) begin
            m_elapsed++;
        end
    endtask

    task automatic checkOutput(input string name, input logic exp);
        checks++;
        if (counting_complete !== exp) begin
            failures++;
            $display("[TB] FAIL %s: counting_complete=%b expected=%b at %0t", name, counting_complete, exp, $time);
        end
    endtask

    task automatic addVec(input logic r, input logic l, input logic e, input logic [15:0] nc,
                          input logic exp, input string name);
        vec_t v;
        v.rst = r; v.load = l; v.enable = e; v.nc = nc; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        // Basic count from 3, then wrap with the flag sticking.
        addVec(1, 0, 0, 16'd0, 0, "reset");
        addVec(0, 1, 0, 16'd3, 0, "load3");
        addVec(0, 0, 0, 16'd0, 0, "cnt3_e1");
        addVec(0, 0, 0, 16'd0, 0, "cnt3_e2");
        addVec(0, 0, 0, 16'd0, 1, "cnt3_e3_tc");
        addVec(0, 0, 0, 16'd0, 1, "cnt3_wrap_sticky");
        // Reload mid-count held for two edges, enable ignored while loading.
        addVec(0, 1, 1, 16'd4, 0, "reload4_clears");
        addVec(0, 1, 0, 16'd4, 0, "reload4_held");
        addVec(0, 0, 0, 16'd0, 0, "cnt4_e1");
        addVec(0, 0, 0, 16'd0, 0, "cnt4_e2");
        addVec(0, 0, 0, 16'd0, 0, "cnt4_e3");
        addVec(0, 0, 0, 16'd0, 1, "cnt4_e4_tc");
        // Reset wins over load, then stays disarmed.
        addVec(1, 1, 0, 16'd7, 0, "rst_vs_load");
        addVec(0, 0, 0, 16'd0, 0, "disarmed_1");
        addVec(0, 0, 0, 16'd0, 0, "disarmed_2");
        addVec(0, 0, 0, 16'd0, 0, "disarmed_3");
        // Gate pause: load 5, two counts, three frozen, then three more counts.
        addVec(0, 1, 0, 16'd5, 0, "load5");
        addVec(0, 0, 0, 16'd0, 0, "cnt5_e1");
        addVec(0, 0, 0, 16'd0, 0, "cnt5_e2");
        addVec(0, 0, 1, 16'd0, 0, "pause_1");
        addVec(0, 0, 1, 16'd0, 0, "pause_2");
        addVec(0, 0, 1, 16'd0, 0, "pause_3");
        addVec(0, 0, 0, 16'd0, 0, "resume_1");
        addVec(0, 0, 0, 16'd0, 0, "resume_2");
        addVec(0, 0, 0, 16'd0, 1, "resume_3_tc");
        addVec(0, 0, 1, 16'd0, 1, "paused_after_tc");

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].load, vecs[i].enable, vecs[i].nc);
            checkOutput(vecs[i].name, vecs[i].exp);
        end

        // Reset mid-count abandons the count for good.
        applyStimulus(0, 1, 0, 16'd10);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 16'd0);
        applyStimulus(1, 0, 0, 16'd0);
        checkOutput("rst_midcount", 1'b0);
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(0, 0, 0, 16'd0);
            if (i == 10 || i == 20) checkOutput("rst_midcount_idle", 1'b0);
        end

        // Loading zero means a full 65536-edge count.
        applyStimulus(0, 1, 1, 16'd0);
        checkOutput("zero_load", 1'b0);
        for (int i = 1; i <= 65536; i++) begin
            applyStimulus(0, 0, 0, 16'd0);
            if (i == 1 || i == 32768 || i == 65535) checkOutput("zero_pre_tc", 1'b0);
            if (i == 65536) checkOutput("zero_tc_65536", 1'b1);
        end
        applyStimulus(0, 0, 0, 16'd0);
        checkOutput("zero_post_tc", 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic        r, l, e;
            logic [15:0] nc;
            r  = ($urandom_range(0, 59) == 0);
            l  = ($urandom_range(0, 9) == 0);
            e  = ($urandom_range(0, 3) == 0);
            nc = ($urandom_range(0, 19) == 0) ? 16'd1 : 16'($urandom_range(1, 30));
            applyStimulus(r, l, e, nc);
            checkOutput("random", model_cc());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
